alu_result_seq: RTL and testbench
=================================

Name: alu_result_seq

Overview:
- Parametrised, registered successor to the CPU's combinational ALU result selector.
- Selects one of five single-cycle ALU lane results (AND, OR, ADD, SLT, XOR) by opcode and presents it as a registered WIDTH-bit result.
- Adds the multiply lane as an iterative unsigned shift-add multiplier with a start/busy/valid handshake.
- Sits between the ALU lane logic and the register-file writeback path.

Parameters:
- WIDTH, 24, datapath width of all lanes, operands and result.
- CNT_W, $clog2(WIDTH), width of the multiplier iteration counter (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sel  in  3  opcode: 0 AND, 1 OR, 2 ADD, 3 SLT, 4 MUL, 5 XOR, 6/7 illegal
- in_and  in  WIDTH  AND lane result
- in_or  in  WIDTH  OR lane result
- in_add  in  WIDTH  adder lane result
- in_slt  in  WIDTH  set-less-than lane result
- in_xor  in  WIDTH  XOR lane result
- mul_a  in  WIDTH  multiplicand (unsigned)
- mul_b  in  WIDTH  multiplier (unsigned)
- result  out  WIDTH  registered result; holds until the next completion
- valid  out  1  one-cycle pulse when result is updated
- busy  out  1  high while a MUL is in progress
- mul_ovf  out  1  high-half-nonzero flag of the last MUL; updated with valid
- sel_err  out  1  one-cycle pulse with valid on an illegal sel

Behaviour:
- Reset (async, rst=1): FSM→IDLE, result=0, valid=0, busy=0, mul_ovf=0, sel_err=0, counter=0, internal product/operand registers=0.
  - Takes effect immediately, including mid-MUL; the partial product is discarded and no valid is issued.
- FSM states: IDLE, MUL.
- Default every cycle: valid=0, sel_err=0.
- IDLE, start=1, sel in {0,1,2,3,5}:
  - At edge k, result←selected lane; valid=1 during cycle k+1.
  - Latency 1; state stays IDLE; mul_ovf unchanged.
- IDLE, start=1, sel in {6,7}:
  - At edge k, result←0, valid=1, sel_err=1 for one cycle.
  - mul_ovf unchanged.
- IDLE, start=1, sel=4:
  - At edge k, latch mul_a and mul_b, clear the 2*WIDTH accumulator, counter←0, state→MUL, busy←1.
- MUL iteration, one per edge: if multiplier bit0=1, acc_hi += multiplicand; then shift right {carry, acc}; counter++.
  - Equivalent formulations are allowed if cycle timing is identical.
- MUL completion: the final (WIDTH-th) iteration occurs at edge k+WIDTH (counter==WIDTH-1 before it). At that edge:
  - result←product[WIDTH-1:0]
  - mul_ovf←|product[2*WIDTH-1:WIDTH]
  - valid←1
  - busy←0
  - state→IDLE
- MUL latency = WIDTH cycles from the start edge; busy is high during cycles k+1..k+WIDTH.
- start while in MUL (busy=1): ignored, not queued; lane inputs and mul_a/mul_b are don't-care.
- start in the cycle where valid=1: state is IDLE, so it is accepted normally (back-to-back throughput).
- Operand changes after the start edge do not affect an in-flight MUL.
- Zero operands: MUL still takes WIDTH cycles; result=0, mul_ovf=0.
- Arithmetic: unsigned, full 2*WIDTH product internally; result truncated to the low WIDTH bits.

Decomposition:
- Shared header/package alu_pkg: the SEL_AND..SEL_XOR opcode constants (3'd0..3'd5) and the FSM state encodings. CPU decode and this block use the same constants.
- One sub-module, seq_mul_core: operand/accumulator registers, counter and done strobe, parametrised by WIDTH.
- alu_result_seq owns the FSM, lane select, output registers and flags.

Test Plan (WIDTH=24):
- Reset then idle → result=0x000000, valid=0, busy=0, mul_ovf=0, sel_err=0.
- start, sel=2, in_add=0xABCDEF → next cycle result=0xABCDEF, valid=1 for exactly one cycle; the same for sel 0/1/3/5 with distinct lane values.
- start, sel=4, a=0x000003, b=0x000005 → busy high for 24 cycles; valid on cycle 24 after start; result=0x00000F, mul_ovf=0.
- start, sel=4, a=0x001000, b=0x001000 → result=0x000000, mul_ovf=1. Also a=0xFFFFFF, b=0x000002 → result=0xFFFFFE, mul_ovf=1.
- MUL in flight with start pulsed (sel=2) at cycle 10 → ignored, MUL result correct. Then start sel=1 in the valid cycle → accepted, valid on the following cycle.
- Assert rst at cycle 12 of a MUL → all outputs 0 immediately, no valid. After release, start sel=6 → result=0, valid=1, sel_err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and FSM encodings shared by CPU decode and the ALU result sequencer.
package alu_pkg;

  localparam logic [2:0] SEL_AND = 3'd0;
  localparam logic [2:0] SEL_OR  = 3'd1;
  localparam logic [2:0] SEL_ADD = 3'd2;
  localparam logic [2:0] SEL_SLT = 3'd3;
  localparam logic [2:0] SEL_MUL = 3'd4;
  localparam logic [2:0] SEL_XOR = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Opcodes 6 and 7 are unassigned; everything else has a lane.
  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel <= SEL_XOR);
  endfunction

endpackage

// File: rtl/alu_result_seq_if.sv
// Request/result bundle between the ALU lanes, the sequencer and writeback.
interface alu_result_seq_if #(
  parameter int WIDTH = 24
) ();

  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] in_and;
  logic [WIDTH-1:0] in_or;
  logic [WIDTH-1:0] in_add;
  logic [WIDTH-1:0] in_slt;
  logic [WIDTH-1:0] in_xor;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;
  logic             mul_ovf;
  logic             sel_err;

  modport master (
    output start, sel, in_and, in_or, in_add, in_slt, in_xor, mul_a, mul_b,
    input  result, valid, busy, mul_ovf, sel_err
  );

  modport slave (
    input  start, sel, in_and, in_or, in_add, in_slt, in_xor, mul_a, mul_b,
    output result, valid, busy, mul_ovf, sel_err
  );

endinterface

// File: rtl/alu_result_seq_mul_core.sv
// Iterative unsigned shift-add multiplier: one multiplier bit retired per clock,
// WIDTH clocks per product. prod_next is the accumulator value the current edge loads.
module seq_mul_core #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod_next
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               run;
  logic [WIDTH:0]     sum;

  // Add into the high half with carry kept, then the whole {carry, acc} shifts right.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    prod_next = {sum, acc[WIDTH-1:1]};
  end

  assign done = run && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= prod_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_result_seq.sv
// Registered ALU result selector: single-cycle lanes complete in one clock,
// MUL runs on the iterative core and completes WIDTH clocks after its start edge.
module alu_result_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  alu_result_seq_if.slave  bus
);

  logic [0:0]         state;
  logic [WIDTH-1:0]   result_q;
  logic               valid_q;
  logic               busy_q;
  logic               mul_ovf_q;
  logic               sel_err_q;

  logic               mul_load;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod_next;
  logic [WIDTH-1:0]   lane_val;

  assign mul_load = (state == ST_IDLE) && bus.start && (bus.sel == SEL_MUL);

  seq_mul_core #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .a         (bus.mul_a),
    .b         (bus.mul_b),
    .done      (mul_done),
    .prod_next (mul_prod_next)
  );

  // Illegal opcodes (and MUL, which never takes this path) yield zero.
  always_comb begin
    lane_val = '0;
    case (bus.sel)
      SEL_AND: lane_val = bus.in_and;
      SEL_OR:  lane_val = bus.in_or;
      SEL_ADD: lane_val = bus.in_add;
      SEL_SLT: lane_val = bus.in_slt;
      SEL_XOR: lane_val = bus.in_xor;
      default: lane_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      mul_ovf_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.sel == SEL_MUL) begin
              state  <= ST_MUL;
              busy_q <= 1'b1;
            end else begin
              result_q  <= lane_val;
              valid_q   <= 1'b1;
              sel_err_q <= !sel_is_legal(bus.sel);
            end
          end
        end
        ST_MUL: begin
          // start is ignored here; only the core's final iteration ends the op.
          if (mul_done) begin
            result_q  <= mul_prod_next[WIDTH-1:0];
            mul_ovf_q <= |mul_prod_next[2*WIDTH-1:WIDTH];
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.mul_ovf = mul_ovf_q;
  assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_alu_result_seq.sv
// Scoreboard bench for alu_result_seq: lane selects, MUL timing/overflow,
// ignored start while busy, back-to-back accept, mid-MUL reset, illegal opcodes.
module tb_alu_result_seq;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_seq_if #(.WIDTH(W)) bus ();

  alu_result_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  logic model_ovf;
  int   errors = 0;
  int   checks = 0;

  task automatic drive_idle();
    bus.start  = 1'b0;
    bus.sel    = 3'd0;
    bus.in_and = '0;
    bus.in_or  = '0;
    bus.in_add = '0;
    bus.in_slt = '0;
    bus.in_xor = '0;
    bus.mul_a  = '0;
    bus.mul_b  = '0;
  endtask

  // Drive one start request (call just after a negedge) and push its expected outcome.
  task automatic issue(input logic [2:0] s, input logic [W-1:0] v,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    exp_t e;
    bus.start  = 1'b1;
    bus.sel    = s;
    bus.in_and = v ^ 24'h111111;
    bus.in_or  = v ^ 24'h222222;
    bus.in_add = v ^ 24'h333333;
    bus.in_slt = v ^ 24'h444444;
    bus.in_xor = v ^ 24'h555555;
    bus.mul_a  = a;
    bus.mul_b  = b;
    case (s)
      3'd0: bus.in_and = v;
      3'd1: bus.in_or  = v;
      3'd2: bus.in_add = v;
      3'd3: bus.in_slt = v;
      3'd5: bus.in_xor = v;
      default: ;
    endcase
    e.err = 1'b0;
    if (s == 3'd4) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.res = p[W-1:0];
      model_ovf = (p[2*W-1:W] != '0);
    end else if (s >= 3'd6) begin
      e.res = '0;
      e.err = 1'b1;
    end else begin
      e.res = v;
    end
    e.ovf = model_ovf;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.result !== 24'h000000) begin errors++; $display("FAIL reset_result: got %h expected 000000", bus.result); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.mul_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.mul_ovf); end
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL reset_selerr: got %b expected 0", bus.sel_err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", bus.valid); end
  endtask

  task automatic test_lanes();
    logic [2:0]   sels [5] = '{3'd2, 3'd0, 3'd1, 3'd3, 3'd5};
    logic [W-1:0] vals [5] = '{24'hABCDEF, 24'h0F0F0F, 24'hF0F0F1, 24'h000001, 24'h5A5A5A};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(sels[i], vals[i], '0, '0);
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL lane%0d_valid: got %b expected 1", sels[i], bus.valid); end
      if (sbq.size() == 0) begin
        errors++; $display("FAIL lane%0d_sb: scoreboard empty", sels[i]);
      end else begin
        e = sbq.pop_front();
        checks++; if (bus.result !== e.res) begin errors++; $display("FAIL lane%0d_result: got %h expected %h", sels[i], bus.result, e.res); end
        checks++; if (bus.sel_err !== e.err || bus.mul_ovf !== e.ovf) begin errors++; $display("FAIL lane%0d_flags: got err=%b ovf=%b expected err=%b ovf=%b", sels[i], bus.sel_err, bus.mul_ovf, e.err, e.ovf); end
      end
      @(negedge clk);
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL lane%0d_pulse: valid got %b expected 0", sels[i], bus.valid); end
    end
  endtask

  // inject_at>0 pulses an ADD start while busy; chain issues OR in the valid cycle.
  task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input bit chain);
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   seen = 0;
    exp_t e;
    issue(3'd4, '0, a, b);
    while (!seen && cyc < W + 10) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.mul_a = W'($urandom);
      bus.mul_b = W'($urandom);
      if (bus.busy) busy_cnt++;
      if (bus.valid) seen = 1;
      if (!seen && cyc == inject_at) begin
        bus.start  = 1'b1;
        bus.sel    = 3'd2;
        bus.in_add = W'($urandom);
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mul_timeout: no valid within %0d cycles", W + 10); end
    checks++; if (cyc != W + 1) begin errors++; $display("FAIL mul_latency: valid after %0d negedges expected %0d", cyc, W + 1); end
    checks++; if (busy_cnt != W) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected %0d", busy_cnt, W); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b expected 0", bus.busy); end
    if (sbq.size() == 0) begin
      errors++; $display("FAIL mul_sb: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      checks++; if (bus.result !== e.res) begin errors++; $display("FAIL mul_result %h*%h: got %h expected %h", a, b, bus.result, e.res); end
      checks++; if (bus.mul_ovf !== e.ovf || bus.sel_err !== 1'b0) begin errors++; $display("FAIL mul_flags %h*%h: got ovf=%b err=%b expected ovf=%b err=0", a, b, bus.mul_ovf, bus.sel_err, e.ovf); end
    end
    if (chain) begin
      issue(3'd1, 24'h13579B, '0, '0);
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", bus.valid); end
      if (sbq.size() == 0) begin
        errors++; $display("FAIL b2b_sb: scoreboard empty");
      end else begin
        e = sbq.pop_front();
        checks++; if (bus.result !== e.res || bus.mul_ovf !== e.ovf) begin errors++; $display("FAIL b2b_result: got %h ovf=%b expected %h ovf=%b", bus.result, bus.mul_ovf, e.res, e.ovf); end
      end
    end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mul_pulse: valid got %b expected 0", bus.valid); end
  endtask

  task automatic test_illegal(input logic [2:0] s);
    exp_t e;
    issue(s, 24'h777777, '0, '0);
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.valid !== 1'b1 || bus.sel_err !== 1'b1) begin errors++; $display("FAIL illegal%0d_strobe: got valid=%b err=%b expected 1 1", s, bus.valid, bus.sel_err); end
    if (sbq.size() == 0) begin
      errors++; $display("FAIL illegal%0d_sb: scoreboard empty", s);
    end else begin
      e = sbq.pop_front();
      checks++; if (bus.result !== e.res || bus.mul_ovf !== e.ovf) begin errors++; $display("FAIL illegal%0d_result: got %h ovf=%b expected %h ovf=%b", s, bus.result, bus.mul_ovf, e.res, e.ovf); end
    end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0 || bus.sel_err !== 1'b0) begin errors++; $display("FAIL illegal%0d_pulse: got valid=%b err=%b expected 0 0", s, bus.valid, bus.sel_err); end
  endtask

  task automatic test_reset_mid_mul();
    int stray = 0;
    issue(3'd4, '0, 24'h123456, 24'h654321);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus.busy); end
    #1 rst = 1'b1;
    sbq.delete();
    model_ovf = 1'b0;
    #1;
    checks++; if (bus.result !== '0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.mul_ovf !== 1'b0 || bus.sel_err !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs: got result=%h valid=%b busy=%b ovf=%b err=%b expected all 0", bus.result, bus.valid, bus.busy, bus.mul_ovf, bus.sel_err); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < W + 5; c++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_no_valid: %0d cycles with valid/busy after reset, expected 0", stray); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lanes();
    test_mul(24'h000003, 24'h000005, 0, 1'b0);
    test_mul(24'h001000, 24'h001000, 0, 1'b0);
    test_mul(24'hFFFFFF, 24'h000002, 10, 1'b1);
    test_illegal(3'd7);
    test_mul(24'h000000, 24'hABCDEF, 0, 1'b0);
    test_mul(24'hFFFFFF, 24'h000002, 0, 1'b0);
    test_reset_mid_mul();
    test_illegal(3'd6);
    test_mul(24'h000ABC, 24'h000DEF, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
